// File: rtl/serial_scan_pkg.sv
// Shared types and constants for the serial scan controller.
package serial_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ID_W = 1;

endpackage

// File: rtl/serial_scan_arb_if.sv
// Requester, detector-pin and response bundle of serial_scan_arb.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; the producer holds valid and data stable until then.
interface serial_scan_arb_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_word;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_word;
  logic             req1_ready;
  logic             det_rst;
  logic             det_data;
  logic             det_out;
  logic             resp_valid;
  logic             resp_id;
  logic [CNT_W-1:0] resp_count;
  logic             resp_ready;

  modport master (
    output req0_valid, req0_word, req1_valid, req1_word, det_out, resp_ready,
    input  req0_ready, req1_ready, det_rst, det_data, resp_valid, resp_id, resp_count
  );

  modport slave (
    input  req0_valid, req0_word, req1_valid, req1_word, det_out, resp_ready,
    output req0_ready, req1_ready, det_rst, det_data, resp_valid, resp_id, resp_count
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the requester not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       gnt_id,
  output logic       any_valid
);
  always_comb begin
    any_valid = |valid;
    gnt_id    = (valid == 2'b11) ? ~last_grant : valid[1];
    grant     = 2'b00;
    if (any_valid) grant = gnt_id ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/serial_scan_arb.sv
// Shares one serial detector between two requesters: clear it, shift a word
// in MSB-first, count cycles with det_out high, and return the count.
module serial_scan_arb
  import serial_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_scan_arb_if.slave    bus,
  output state_t              state_dbg
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state, state_nx;
  logic              last_grant;
  logic [WIDTH-1:0]  shreg;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  idx;
  logic [ID_W-1:0]   resp_id_q;
  logic [1:0]        grant;
  logic              gnt_id;
  logic              any_valid;

  rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .grant      (grant),
    .gnt_id     (gnt_id),
    .any_valid  (any_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      shreg      <= '0;
      count      <= '0;
      idx        <= '0;
      resp_id_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (any_valid) begin
          shreg     <= gnt_id ? bus.req1_word : bus.req0_word;
          resp_id_q <= gnt_id;
          count     <= '0;
          idx       <= '0;
        end
        SHIFT: begin
          // Saturate rather than wrap when the detector fires more often than CNT_W can hold.
          if (bus.det_out && (count != CNT_MAX)) count <= count + 1'b1;
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          idx   <= idx + 1'b1;
        end
        RESP: if (bus.resp_ready) last_grant <= resp_id_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_valid) state_nx = CLEAR;
      CLEAR:   state_nx = SHIFT;
      SHIFT:   if (idx == IDX_LAST) state_nx = RESP;
      RESP:    if (bus.resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ready is the only output allowed to depend on inputs; it is held low while in reset.
  assign bus.req0_ready = rst && (state == IDLE) && grant[0];
  assign bus.req1_ready = rst && (state == IDLE) && grant[1];
  assign bus.det_rst    = (state != SHIFT);
  assign bus.det_data   = (state == SHIFT) && shreg[WIDTH-1];
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_id    = (state == RESP) ? resp_id_q : 1'b0;
  assign bus.resp_count = (state == RESP) ? count : '0;
  assign state_dbg      = state;
endmodule

// File: tb/tb_serial_scan_arb.sv
// Bench for serial_scan_arb with a det_out = det_data detector stub.
module tb_serial_scan_arb;
  import serial_scan_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t dbg, dbg_s;

  serial_scan_arb_if #(.WIDTH(8), .CNT_W(4)) b();
  serial_scan_arb_if #(.WIDTH(8), .CNT_W(2)) s();

  assign b.det_out = b.det_data;
  assign s.det_out = s.det_data;

  serial_scan_arb #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(b.slave), .state_dbg(dbg)
  );
  serial_scan_arb #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(s.slave), .state_dbg(dbg_s)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference model
  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  int         model_last = 1;
  logic       pend_v[2];
  logic [7:0] pend_w[2];

  typedef struct {
    int         who;
    logic [7:0] word;
    int         bp;
    int         cnt;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_count(input logic [7:0] w, input int cw);
    int n = 0;
    int m = (1 << cw) - 1;
    for (int i = 0; i < 8; i++) n += int'(w[i]);
    return (n > m) ? m : n;
  endfunction

  function automatic int model_winner();
    if (pend_v[0] && pend_v[1]) return 1 - model_last;
    return pend_v[1] ? 1 : 0;
  endfunction

  // driver tasks
  task automatic set_req(input int who, input logic v, input logic [7:0] w);
    if (who == 0) begin
      b.req0_valid = v; b.req0_word = w;
    end else begin
      b.req1_valid = v; b.req1_word = w;
    end
    pend_v[who] = v;
    pend_w[who] = w;
  endtask

  task automatic arm_random();
    for (int r = 0; r < 2; r++)
      if (!pend_v[r] && ($urandom_range(0, 1) == 1)) set_req(r, 1'b1, 8'($urandom_range(0, 255)));
  endtask

  // Call at a negedge while IDLE; returns one edge after the accepting edge.
  task automatic wait_accept(output int id, output logic [7:0] w, output int exp_id, output int waited);
    id = -1; w = '0; waited = 0;
    exp_id = model_winner();
    for (int k = 0; k < 40; k++) begin
      #1;
      if (b.req0_ready || b.req1_ready) begin
        id = b.req1_ready ? 1 : 0;
        check("ready_onehot", 32'(b.req0_ready & b.req1_ready), 0);
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (id < 0) begin
      check("accept_timeout", 1, 0);
      id = exp_id;
    end
    check("grant", id, exp_id);
    w = pend_w[id];
    @(posedge clk); #1;
    set_req(id, 1'b0, pend_w[id]);
  endtask

  // Follows CLEAR, SHIFT and RESP; bp cycles of resp_ready=0 before the handshake.
  task automatic observe(input logic [7:0] w, input int bp);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    b.resp_ready = 1'b0;
    @(negedge clk);
    check("clear_state", 32'(dbg), 32'(CLEAR));
    check("clear_rst", 32'(b.det_rst), 1);
    check("clear_data", 32'(b.det_data), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("shift_data", 32'(b.det_data), 32'(w[7-i]));
      check("shift_rst", 32'(b.det_rst), 0);
      check("shift_ready", 32'(b.req0_ready | b.req1_ready), 0);
    end
    for (int k = 0; k <= bp; k++) begin
      @(negedge clk);
      check("resp_valid", 32'(b.resp_valid), 1);
      check("resp_id", 32'(b.resp_id), 32'(e[4]));
      check("resp_count", 32'(b.resp_count), 32'(e[3:0]));
      check("resp_det_rst", 32'(b.det_rst), 1);
      check("resp_ready_blk", 32'(b.req0_ready | b.req1_ready), 0);
      b.resp_ready = (k == bp);
    end
    model_last = int'(e[4]);
    @(negedge clk);
    b.resp_ready = 1'b0;
    check("resp_drop", 32'(b.resp_valid), 0);
    check("idle_count", 32'(b.resp_count), 0);
  endtask

  initial begin
    int         id, exp_id, waited, seen;
    logic [7:0] w;

    vecs[0] = '{who: 0, word: 8'hB5, bp: 0, cnt: 5};
    vecs[1] = '{who: 1, word: 8'hFF, bp: 2, cnt: 8};
    vecs[2] = '{who: 0, word: 8'h00, bp: 0, cnt: 0};
    vecs[3] = '{who: 1, word: 8'h81, bp: 1, cnt: 2};
    vecs[4] = '{who: 0, word: 8'h7E, bp: 5, cnt: 6};
    vecs[5] = '{who: 1, word: 8'h01, bp: 0, cnt: 1};

    b.resp_ready = 1'b0;
    s.req0_valid = 1'b0; s.req0_word = '0;
    s.req1_valid = 1'b0; s.req1_word = '0;
    s.resp_ready = 1'b0;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;

    // Reset with both requesters waiting: FF on 0, 00 on 1.
    set_req(0, 1'b1, 8'hFF);
    set_req(1, 1'b1, 8'h00);
    repeat (2) begin
      @(negedge clk);
      check("rst_resp_valid", 32'(b.resp_valid), 0);
      check("rst_det_rst", 32'(b.det_rst), 1);
      check("rst_det_data", 32'(b.det_data), 0);
      check("rst_ready0", 32'(b.req0_ready), 0);
      check("rst_ready1", 32'(b.req1_ready), 0);
      check("rst_resp_id", 32'(b.resp_id), 0);
    end
    rst = 1'b1;

    // Contention: req0 first, then req1, with backpressure on the second result.
    wait_accept(id, w, exp_id, waited);
    check("first_after_reset", waited, 0);
    exp_q.push_back({1'(exp_id), 4'(model_count(w, 4))});
    observe(w, 0);
    wait_accept(id, w, exp_id, waited);
    check("second_accept_latency", waited, 0);
    exp_q.push_back({1'(exp_id), 4'(model_count(w, 4))});
    set_req(0, 1'b1, 8'h3C);
    set_req(1, 1'b1, 8'h0F);
    observe(w, 5);
    wait_accept(id, w, exp_id, waited);
    check("tie_after_bp", id, 0);
    check("accept_after_handshake", waited, 0);
    exp_q.push_back({1'(exp_id), 4'(model_count(w, 4))});
    observe(w, 0);
    wait_accept(id, w, exp_id, waited);
    exp_q.push_back({1'(exp_id), 4'(model_count(w, 4))});
    observe(w, 1);

    // Table: lone requester jobs with hand-computed counts.
    foreach (vecs[i]) begin
      set_req(vecs[i].who, 1'b1, vecs[i].word);
      wait_accept(id, w, exp_id, waited);
      check("table_grant", id, vecs[i].who);
      exp_q.push_back({1'(vecs[i].who), 4'(vecs[i].cnt)});
      observe(w, vecs[i].bp);
    end

    // Randomized jobs against the reference model.
    for (int j = 0; j < 16; j++) begin
      arm_random();
      if (!pend_v[0] && !pend_v[1]) set_req(int'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 255)));
      wait_accept(id, w, exp_id, waited);
      exp_q.push_back({1'(exp_id), 4'(model_count(w, 4))});
      arm_random();
      observe(w, int'($urandom_range(0, 3)));
    end
    while (pend_v[0] || pend_v[1]) begin
      wait_accept(id, w, exp_id, waited);
      exp_q.push_back({1'(exp_id), 4'(model_count(w, 4))});
      observe(w, 0);
    end

    // Mid-scan reset: B5 job dropped at cycle 5, no response ever.
    set_req(0, 1'b1, 8'hB5);
    wait_accept(id, w, exp_id, waited);
    repeat (5) @(negedge clk);
    check("mid_in_shift", 32'(dbg), 32'(SHIFT));
    rst = 1'b0;
    exp_q.delete();
    model_last = 1;
    @(negedge clk);
    check("mid_state", 32'(dbg), 32'(IDLE));
    check("mid_det_rst", 32'(b.det_rst), 1);
    check("mid_det_data", 32'(b.det_data), 0);
    check("mid_resp_valid", 32'(b.resp_valid), 0);
    rst = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (b.resp_valid) seen++;
    end
    check("mid_no_resp", seen, 0);

    // Saturation on the CNT_W=2 instance.
    s.req0_word = 8'hFF;
    s.req0_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (s.req0_ready) begin seen = 1; break; end
      @(negedge clk);
    end
    check("sat_accept", seen, 1);
    @(posedge clk); #1;
    s.req0_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (s.resp_valid) begin seen = 1; break; end
    end
    check("sat_resp_seen", seen, 1);
    check("sat_count", 32'(s.resp_count), 3);
    check("sat_id", 32'(s.resp_id), 0);
    s.resp_ready = 1'b1;
    @(negedge clk);
    s.resp_ready = 1'b0;
    check("sat_drop", 32'(s.resp_valid), 0);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_scan_arb.md
# serial_scan_arb

Scan controller that shares one serial Mealy sequence detector between two requesters. Each granted requester hands over a parallel word. The block clears the detector, shifts the word into it MSB-first one bit per clock, and counts the cycles in which the detector output is high. It returns the match count with the requester's ID. The block sits between the requester ports and the detector's data/clear/out pins; the detector itself is instantiated alongside it.

## Interface
- WIDTH, 8, bits per scanned word (≥2)
- CNT_W, 4, match-count width; legal configs have CNT_W ≥ clog2(WIDTH+1)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low: one clock, reset synchronous and active-low
- req0_valid  in  1  requester 0 has a word
- req0_word  in  WIDTH  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle
- req1_valid / req1_word / req1_ready  same as requester 0, for requester 1
- det_rst  out  1  active-high clear to detector
- det_data  out  1  serial bit to detector
- det_out  in  1  detector Mealy output; combinational on det_data, same cycle
- resp_valid  out  1  result available
- resp_id  out  1  requester that owns the result
- resp_count  out  CNT_W  number of det_out-high SHIFT cycles
- resp_ready  in  1  consumer takes result

## Operation
- States: IDLE, CLEAR, SHIFT, RESP.
- IDLE: det_rst=1. If any reqN_valid, grant round-robin: the requester not granted last wins a tie, and a lone requester always wins. reqN_ready=1 combinationally for the winner only. On that edge:
  - capture word into shift register and ID;
  - zero count and bit index;
  - go to CLEAR.
- CLEAR: det_rst=1 for exactly one cycle, det_data=0; go to SHIFT.
- SHIFT: det_rst=0, det_data=shreg[WIDTH-1]. Each edge:
  - count += det_out;
  - shift left one place;
  - index++.
  - After WIDTH SHIFT cycles, go to RESP.
- Count saturates at 2^CNT_W−1; it never wraps.
- RESP: resp_valid=1, with resp_id and resp_count stable. det_rst=1. On resp_valid&resp_ready:
  - last_grant ← resp_id;
  - go to IDLE.
- reqN_ready=0 in every state except IDLE. Requesters must hold valid/word until ready.
- Reset (rst=0 at an edge) from any state:
  - state=IDLE, last_grant=1 (requester 0 has first priority);
  - count=0, shreg=0, resp_id=0;
  - any in-flight job is dropped with no response.
- Output values while in reset/IDLE: resp_valid=0, resp_count=0, resp_id=0, det_rst=1, det_data=0, reqN_ready=0 during reset.

## Timing
- Cycle 0: accept (IDLE, ready=1).
- Cycle 1: CLEAR.
- Cycles 2..WIDTH+1: SHIFT, with bit WIDTH-1−(c−2) on det_data.
- Cycle WIDTH+2: first resp_valid cycle.
- Minimum job length: WIDTH+3 cycles; the next accept is at the earliest the cycle after the response handshake.
- All outputs except reqN_ready are decoded from registered state only.

## Structure
- Package serial_scan_pkg holds:
  - state encoding constants: IDLE=2'd0, CLEAR=2'd1, SHIFT=2'd2, RESP=2'd3;
  - the ID width constant.
- Sub-module rr_arb2: two-input round-robin grant from the valids and last_grant, purely combinational. The pointer register stays in serial_scan_arb.

## Test plan
All scenarios use a bench detector stub with det_out = det_data, so the count equals the number of ones.
- Reset: rst=0 for 2 cycles with both valids high → resp_valid=0, det_rst=1, det_data=0, both ready=0. First cycle after release → req0_ready=1.
- Single job: req0 word 8'hB5 →
  - det_data = 1,0,1,1,0,1,0,1 in cycles 2–9, det_rst=0 only in those cycles;
  - cycle 10: resp_valid=1, resp_id=0, resp_count=5.
- Contention: both valid, req0=8'hFF, req1=8'h00, resp_ready=1 → first result id 0 / count 8, then id 1 / count 0. Next tie grants req0.
- Backpressure: resp_ready=0 for 5 cycles in RESP →
  - resp_valid/resp_id/resp_count held;
  - both ready=0 despite valid;
  - accept occurs the cycle after the handshake.
- Mid-scan reset: rst=0 at cycle 5 of the 8'hB5 job → next cycle IDLE, det_rst=1, no resp_valid ever for that job.
- Saturation (CNT_W=2, WIDTH=8): word 8'hFF → resp_count=3.
